// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, widths, RCON, the forward S-box
// table, the 128-bit state type and the key-scheduler FSM encoding.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned NUM_KEYS   = NUM_ROUNDS + 1;
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned IDX_W      = 4;

    typedef logic [KEY_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_SERVE  = 2'd2
    } ks_state_t;

    // Round constants, indexed by round number 1..10
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, shared with the encryption datapath
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
// Ports:
//   word        in  32  input word
//   sub_word_c  out 32  substituted word (combinational)
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub_word_c
);

    assign sub_word_c = {sbox(word[31:24]), sbox(word[23:16]),
                         sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 round-key responder: expands a cipher key into 11 stored round
// keys (one per cycle) and then serves one key per request, forward for
// encryption or reverse for decryption, wrapping after the 11th key.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   load             capture cipher_key/decrypt and start expansion
//   cipher_key[128]  cipher key, byte 0 in [127:120]
//   decrypt          sampled with load; 1 = serve keys 10..0
//   req_key          request the next round key (SERVE only)
//   busy             expansion in progress
//   keys_ready       expansion done, requests accepted
//   round_key[128]   registered round key, holds between pulses
//   key_valid        one-cycle pulse with round_key
//   last_key         with key_valid on the final key of a sequence
module aes_key_scheduler
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [KEY_W-1:0] cipher_key,
    input  logic             decrypt,
    input  logic             req_key,
    output logic             busy,
    output logic             keys_ready,
    output logic [KEY_W-1:0] round_key,
    output logic             key_valid,
    output logic             last_key
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    ks_state_t        state;
    ks_state_t        state_next;
    aes_state_t       key_mem [NUM_KEYS];
    logic [IDX_W-1:0] rc;
    logic [IDX_W-1:0] ptr;
    logic             decrypt_q;

    logic [IDX_W-1:0]  prev_idx;
    aes_state_t        prev_key;
    aes_state_t        next_key;
    logic [WORD_W-1:0] rot_w3;
    logic [WORD_W-1:0] sub_w3;
    logic [WORD_W-1:0] temp_w;
    logic [WORD_W-1:0] nw0, nw1, nw2, nw3;
    logic [7:0]        rcon_byte;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  end_idx;
    logic              serve_fire_c;

    // One expansion round: slot rc from slot rc-1
    assign prev_idx  = (rc == '0) ? '0 : rc - IDX_W'(1);
    assign prev_key  = key_mem[prev_idx];
    assign rot_w3    = {prev_key[23:0], prev_key[31:24]};
    assign rcon_byte = (rc >= IDX_W'(1) && rc <= LAST_IDX) ? RCON[rc] : 8'h00;
    assign temp_w    = sub_w3 ^ {rcon_byte, 24'h000000};
    assign nw0       = prev_key[127:96] ^ temp_w;
    assign nw1       = prev_key[95:64]  ^ nw0;
    assign nw2       = prev_key[63:32]  ^ nw1;
    assign nw3       = prev_key[31:0]   ^ nw2;
    assign next_key  = {nw0, nw1, nw2, nw3};

    aes_sub_word u_sub_word (
        .word       (rot_w3),
        .sub_word_c (sub_w3)
    );

    // Serve pointer start/end depend on the direction latched with load
    assign start_idx    = decrypt_q ? LAST_IDX : '0;
    assign end_idx      = decrypt_q ? '0 : LAST_IDX;
    assign serve_fire_c = (state == KS_SERVE) && req_key && !load;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= KS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load restarts from any state
    always_comb begin
        state_next = state;
        case (state)
            KS_IDLE:   state_next = KS_IDLE;
            KS_EXPAND: if (rc == LAST_IDX) state_next = KS_SERVE;
            KS_SERVE:  state_next = KS_SERVE;
            default:   state_next = KS_IDLE;
        endcase
        if (load) begin
            state_next = KS_EXPAND;
        end
    end

    // Key storage, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            rc         <= '0;
            ptr        <= '0;
            decrypt_q  <= 1'b0;
            round_key  <= '0;
            key_valid  <= 1'b0;
            last_key   <= 1'b0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
        end else begin
            busy       <= (state_next == KS_EXPAND);
            keys_ready <= (state_next == KS_SERVE);
            key_valid  <= 1'b0;
            last_key   <= 1'b0;
            if (load) begin
                key_mem[0] <= cipher_key;
                rc         <= IDX_W'(1);
                decrypt_q  <= decrypt;
                ptr        <= decrypt ? LAST_IDX : '0;
            end else if (state == KS_EXPAND) begin
                key_mem[rc] <= next_key;
                rc          <= rc + IDX_W'(1);
            end else if (serve_fire_c) begin
                round_key <= key_mem[ptr];
                key_valid <= 1'b1;
                last_key  <= (ptr == end_idx);
                if (ptr == end_idx) begin
                    ptr <= start_idx;
                end else if (decrypt_q) begin
                    ptr <= ptr - IDX_W'(1);
                end else begin
                    ptr <= ptr + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed bench for aes_key_scheduler: expected keys are queued when a
// request is driven and compared when key_valid appears.
module tb_aes_key_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [127:0] cipher_key;
    logic         decrypt;
    logic         req_key;
    logic         busy;
    logic         keys_ready;
    logic [127:0] round_key;
    logic         key_valid;
    logic         last_key;

    typedef struct {
        logic [127:0] key;
        logic         last;
        logic         care;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_key_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .cipher_key (cipher_key),
        .decrypt    (decrypt),
        .req_key    (req_key),
        .busy       (busy),
        .keys_ready (keys_ready),
        .round_key  (round_key),
        .key_valid  (key_valid),
        .last_key   (last_key)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!keys_ready && n < 20) begin
            tick();
            n++;
        end
        check1("ready_timeout", keys_ready, 1'b1);
    endtask

    // Drive one request for a cycle; the pulse must follow exactly one cycle later
    task automatic request(input logic [127:0] k, input logic last, input logic care);
        exp_t e;
        e.key  = k;
        e.last = last;
        e.care = care;
        sb_q.push_back(e);
        req_key = 1'b1;
        tick();
        req_key = 1'b0;
        check1("kv_latency", key_valid, 1'b1);
    endtask

    // Scoreboard: pop and compare on every key_valid
    always @(negedge clk) begin
        exp_t e;
        if (key_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check1("unexpected_kv", key_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                if (e.care) check128("round_key", round_key, e.key);
                check1("last_key", last_key, e.last);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        req_key    = 1'b0;
        decrypt    = 1'b0;
        cipher_key = '0;
        repeat (3) tick();
        check1("rst_busy", busy, 1'b0);
        check1("rst_ready", keys_ready, 1'b0);
        check1("rst_kv", key_valid, 1'b0);
        check1("rst_last", last_key, 1'b0);
        check128("rst_rk", round_key, '0);
        reset = 1'b0;
        tick();

        // Request in IDLE is ignored
        req_key = 1'b1;
        tick();
        req_key = 1'b0;
        check1("idle_req", key_valid, 1'b0);

        // Forward sequence with load-to-ready timing and an early request
        cipher_key = FIPS_KEY;
        decrypt    = 1'b0;
        load       = 1'b1;
        tick();
        load = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            check1("busy_window", busy, 1'b1);
            check1("ready_low", keys_ready, 1'b0);
            if (n == 6) check1("early_req_ignored", key_valid, 1'b0);
            req_key = (n == 5);
            tick();
        end
        check1("busy_done", busy, 1'b0);
        check1("ready_t11", keys_ready, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            request(fips_rk[k], k == 10, 1'b1);
        end
        tick();
        check1("kv_idle", key_valid, 1'b0);
        check1("last_idle", last_key, 1'b0);
        check128("rk_hold", round_key, fips_rk[10]);

        // Reverse sequence with wrap, restarted by load during SERVE
        cipher_key = FIPS_KEY;
        decrypt    = 1'b1;
        load       = 1'b1;
        tick();
        load = 1'b0;
        check1("ready_drop", keys_ready, 1'b0);
        check1("busy_rise", busy, 1'b1);
        wait_ready();
        for (int k = 0; k <= 10; k++) begin
            request(fips_rk[10-k], k == 10, 1'b1);
            tick();
        end
        request(fips_rk[10], 1'b0, 1'b1);

        // load and req_key together: load wins; new key served in reverse
        cipher_key = SEQ_KEY;
        decrypt    = 1'b1;
        load       = 1'b1;
        req_key    = 1'b1;
        tick();
        load    = 1'b0;
        req_key = 1'b0;
        check1("load_req_kv", key_valid, 1'b0);
        check1("load_req_busy", busy, 1'b1);
        wait_ready();
        request(SEQ_R10, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            request('0, 1'b0, 1'b0);
        end
        request(SEQ_KEY, 1'b1, 1'b1);

        // Reset during expansion, then a clean reload
        cipher_key = FIPS_KEY;
        decrypt    = 1'b0;
        load       = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_ready", keys_ready, 1'b0);
        check1("mid_rst_kv", key_valid, 1'b0);
        check1("mid_rst_last", last_key, 1'b0);
        check128("mid_rst_rk", round_key, '0);
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_ready();
        request(fips_rk[0], 1'b0, 1'b1);
        request(fips_rk[1], 1'b0, 1'b1);

        tick();
        tick();
        check1("sb_drained", sb_q.size() == 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
